// File: rtl/weight_mem_writer_if.sv
// Bundle of the weight-stream, control and memory-write signals of weight_mem_writer.
// The master side drives the stream and control inputs. The slave side is the writer itself.
interface weight_mem_writer_if #(
    parameter int N_ROWS_ARRAY = 20,
    parameter int F_WIDTH      = 8,
    parameter int ADDR_WIDTH   = 16
);
    logic                              start_i;
    logic [ADDR_WIDTH-1:0]             base_addr_i;
    logic [ADDR_WIDTH-1:0]             n_words_i;
    logic                              flush_i;
    logic [F_WIDTH-1:0]                w_data_i;
    logic                              w_valid_i;
    logic                              w_ready_o;
    logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem2_data_o;
    logic [ADDR_WIDTH-1:0]             wr_addrs_mem2_o;
    logic                              wr_mem2_ld_o;
    logic                              busy_o;
    logic                              done_o;

    modport master (
        output start_i, base_addr_i, n_words_i, flush_i, w_data_i, w_valid_i,
        input  w_ready_o, mem2_data_o, wr_addrs_mem2_o, wr_mem2_ld_o, busy_o, done_o
    );

    modport slave (
        input  start_i, base_addr_i, n_words_i, flush_i, w_data_i, w_valid_i,
        output w_ready_o, mem2_data_o, wr_addrs_mem2_o, wr_mem2_ld_o, busy_o, done_o
    );
endinterface

// File: rtl/weight_mem_writer.sv
// Packs a serial stream of signed weights into full-row words and writes them
// into the weight memory, one word per N_ROWS_ARRAY accepted beats.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start_i; outputs hold their last word/address
// S_FILL  | accepting beats into lanes, w_ready_o high
// S_WRITE | one-cycle write strobe of the packed word
// S_DONE  | one-cycle done_o pulse, then back to idle
module weight_mem_writer #(
    parameter int N_ROWS_ARRAY = 20,
    parameter int F_WIDTH      = 8,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic               clk_i,
    input  logic               rd_weight_rst,
    weight_mem_writer_if.slave bus
);
    localparam int CNT_W  = $clog2(N_ROWS_ARRAY + 1);
    localparam int DATA_W = N_ROWS_ARRAY * F_WIDTH;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(N_ROWS_ARRAY);
    localparam logic [ADDR_WIDTH-1:0] ONE_WORD = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                                   state_q, state_d;
    logic [CNT_W-1:0]                         lane_cnt_q, lane_cnt_d;
    logic [N_ROWS_ARRAY-1:0][F_WIDTH-1:0]     lanes_q, lanes_d;
    logic [ADDR_WIDTH-1:0]                    words_left_q, words_left_d;
    logic [ADDR_WIDTH-1:0]                    addr_q, addr_d;
    logic                                     flush_q, flush_d;
    logic [DATA_W-1:0]                        mem_data_q, mem_data_d;
    logic [ADDR_WIDTH-1:0]                    wr_addr_q, wr_addr_d;
    logic                                     w_ready_q, w_ready_d;
    logic                                     wr_ld_q, wr_ld_d;
    logic                                     busy_q, busy_d;
    logic                                     done_q, done_d;
    logic                                     accept;
    logic [CNT_W-1:0]                         cnt_next;

    assign accept = bus.w_valid_i && w_ready_q;

    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state_q      <= S_IDLE;
            lane_cnt_q   <= '0;
            lanes_q      <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            flush_q      <= 1'b0;
            mem_data_q   <= '0;
            wr_addr_q    <= '0;
            w_ready_q    <= 1'b0;
            wr_ld_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_cnt_q   <= lane_cnt_d;
            lanes_q      <= lanes_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            flush_q      <= flush_d;
            mem_data_q   <= mem_data_d;
            wr_addr_q    <= wr_addr_d;
            w_ready_q    <= w_ready_d;
            wr_ld_q      <= wr_ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        lanes_d      = lanes_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
        flush_d      = flush_q;
        mem_data_d   = mem_data_q;
        wr_addr_d    = wr_addr_q;
        cnt_next     = lane_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    addr_d       = bus.base_addr_i;
                    words_left_d = bus.n_words_i;
                    flush_d      = 1'b0;
                    if (bus.n_words_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FILL;
                        lane_cnt_d = '0;
                        lanes_d    = '0;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    lanes_d[lane_cnt_q] = bus.w_data_i;
                    cnt_next            = lane_cnt_q + CNT_W'(1);
                end
                lane_cnt_d = cnt_next;
                // A flush with a partial word still writes it; an empty one just ends.
                if ((cnt_next == FULL_CNT) || (bus.flush_i && (cnt_next != '0))) begin
                    state_d    = S_WRITE;
                    flush_d    = bus.flush_i;
                    mem_data_d = lanes_d;
                    wr_addr_d  = addr_q;
                end else if (bus.flush_i) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                addr_d       = addr_q + ONE_WORD;
                words_left_d = words_left_q - ONE_WORD;
                if (flush_q || (words_left_q == ONE_WORD)) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_FILL;
                    lane_cnt_d = '0;
                    lanes_d    = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the state being entered.
        w_ready_d = (state_d == S_FILL);
        wr_ld_d   = (state_d == S_WRITE);
        busy_d    = (state_d == S_FILL) || (state_d == S_WRITE);
        done_d    = (state_d == S_DONE);
    end

    assign bus.w_ready_o       = w_ready_q;
    assign bus.mem2_data_o     = mem_data_q;
    assign bus.wr_addrs_mem2_o = wr_addr_q;
    assign bus.wr_mem2_ld_o    = wr_ld_q;
    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
endmodule

// File: tb/tb_weight_mem_writer.sv
// Directed bench for weight_mem_writer: expected writes go into a scoreboard queue
// when the beats are planned and are popped by a monitor on every write strobe.
module tb_weight_mem_writer;
    localparam int N  = 20;
    localparam int FW = 8;
    localparam int AW = 16;
    localparam int DW = N * FW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk_i = 1'b0;
    logic rd_weight_rst = 1'b1;

    weight_mem_writer_if #(.N_ROWS_ARRAY(N), .F_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

    weight_mem_writer #(.N_ROWS_ARRAY(N), .F_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_strobes = 0;
    int n_done = 0;
    int strobe_cyc = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    bit ready_seen = 1'b0;
    logic busy_at_done = 1'b0;
    wr_t sb_q[$];
    logic [FW-1:0] beats [0:39];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int first, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*FW +: FW] = beats[first + i];
        return w;
    endfunction

    task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        wr_t e;
        if (bus.w_ready_o) ready_seen = 1'b1;
        if (bus.done_o) begin
            n_done++;
            done_cyc = cyc;
            busy_at_done = bus.busy_o;
        end
        if (bus.wr_mem2_ld_o) begin
            n_strobes++;
            strobe_cyc = cyc;
            chk("ready_low_in_write", bus.w_ready_o, 0);
            chk("write_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("write_addr", bus.wr_addrs_mem2_o, e.addr);
                chk("write_data", bus.mem2_data_o, e.data);
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] n);
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        bus.n_words_i   = n;
        start_cyc       = cyc;
        @(posedge clk_i); #1;
        bus.start_i     = 1'b0;
    endtask

    task automatic send(input int n, input bit rnd, input bit flush_last);
        int idx = 0;
        int budget = 0;
        bit v;
        logic rdy;
        while (idx < n && budget < 1000) begin
            v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.w_valid_i = v;
            bus.w_data_i  = beats[idx];
            bus.flush_i   = flush_last && (idx == n - 1) && v;
            @(negedge clk_i);
            rdy = bus.w_ready_o;
            @(posedge clk_i); #1;
            if (v && rdy) idx++;
            budget++;
        end
        bus.w_valid_i = 1'b0;
        bus.flush_i   = 1'b0;
        chk("beats_accepted", idx, n);
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (n_done < target && b < 200) begin
            @(negedge clk_i);
            b++;
        end
        chk("done_seen", n_done >= target, 1);
        chk("busy_low_at_done", busy_at_done, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int s0;
        int d0;
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.n_words_i   = '0;
        bus.flush_i     = 1'b0;
        bus.w_data_i    = '0;
        bus.w_valid_i   = 1'b0;

        // reset values
        idle(2);
        chk("rst_ready", bus.w_ready_o, 0);
        chk("rst_ld", bus.wr_mem2_ld_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_data", bus.mem2_data_o, 0);
        chk("rst_addr", bus.wr_addrs_mem2_o, 0);
        rd_weight_rst = 1'b0;
        idle(2);

        // two full words, continuous valid
        for (int i = 0; i < 40; i++) beats[i] = FW'(i + 1);
        push_exp(16'h0010, pack(0, 20));
        push_exp(16'h0011, pack(20, 20));
        s0 = n_strobes;
        d0 = n_done;
        start_xfer(16'h0010, 16'd2);
        chk("busy_in_fill", bus.busy_o, 1);
        chk("ready_after_start", bus.w_ready_o, 1);
        send(40, 1'b0, 1'b0);
        wait_done(d0 + 1);
        chk("t1_strobes", n_strobes - s0, 2);
        chk("t1_done_after_strobe", done_cyc - strobe_cyc, 1);
        idle(1);

        // backpressure with signed data
        for (int i = 0; i < 20; i++) beats[i] = (i % 2 == 0) ? 8'hFF : 8'h80;
        push_exp(16'h0100, pack(0, 20));
        s0 = n_strobes;
        d0 = n_done;
        start_xfer(16'h0100, 16'd1);
        send(20, 1'b1, 1'b0);
        wait_done(d0 + 1);
        chk("t2_strobes", n_strobes - s0, 1);
        idle(2);

        // zero words
        s0 = n_strobes;
        d0 = n_done;
        ready_seen = 1'b0;
        start_xfer(16'h0200, 16'd0);
        wait_done(d0 + 1);
        chk("t3_done_latency", done_cyc - start_cyc, 1);
        idle(3);
        chk("t3_strobes", n_strobes - s0, 0);
        chk("t3_ready_never", ready_seen, 0);

        // early flush with the 5th beat
        for (int i = 0; i < 5; i++) beats[i] = FW'(i + 1);
        push_exp(16'h0300, pack(0, 5));
        s0 = n_strobes;
        d0 = n_done;
        start_xfer(16'h0300, 16'd3);
        send(5, 1'b0, 1'b1);
        wait_done(d0 + 1);
        chk("t4_done_after_strobe", done_cyc - strobe_cyc, 1);
        idle(3);
        chk("t4_strobes", n_strobes - s0, 1);
        chk("t4_single_done", n_done - d0, 1);

        // address wrap
        for (int i = 0; i < 40; i++) beats[i] = FW'(8'h50 + i);
        push_exp(16'hFFFF, pack(0, 20));
        push_exp(16'h0000, pack(20, 20));
        s0 = n_strobes;
        d0 = n_done;
        start_xfer(16'hFFFF, 16'd2);
        send(40, 1'b0, 1'b0);
        wait_done(d0 + 1);
        chk("t5_strobes", n_strobes - s0, 2);
        idle(1);

        // reset mid-transfer after 7 beats
        for (int i = 0; i < 7; i++) beats[i] = FW'(8'hA0 + i);
        d0 = n_done;
        start_xfer(16'h0400, 16'd1);
        send(7, 1'b0, 1'b0);
        rd_weight_rst = 1'b1;
        #1;
        chk("abort_ready", bus.w_ready_o, 0);
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_ld", bus.wr_mem2_ld_o, 0);
        chk("abort_data", bus.mem2_data_o, 0);
        chk("abort_addr", bus.wr_addrs_mem2_o, 0);
        @(posedge clk_i); #1;
        rd_weight_rst = 1'b0;
        idle(3);
        chk("abort_no_done", n_done, d0);
        for (int i = 0; i < 20; i++) beats[i] = FW'(8'h30 + i);
        push_exp(16'h0500, pack(0, 20));
        s0 = n_strobes;
        start_xfer(16'h0500, 16'd1);
        send(20, 1'b0, 1'b0);
        wait_done(d0 + 1);
        chk("t6_strobes", n_strobes - s0, 1);
        idle(2);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_mem_writer.md
# weight_mem_writer

Packs a serial stream of signed filter weights into full-row words and writes them into the weight memory over its write port (`mem2_data_i` / `wr_addrs_mem2_i` / `wr_mem2_ld_i`). It is the producer side of the weight path: the array controller later reads these words back, one per round. The block sits between the host/DMA weight stream and the weight memory. It runs on the same clock and reset as the weight holding register.

## Interface

Parameters:
- `N_ROWS_ARRAY`, 20, number of weight lanes per memory word (one per array row).
- `F_WIDTH`, 8, bits per weight (two's complement).
- `ADDR_WIDTH`, 16, weight memory address width.

Ports:
- `clk_i`  in  1  clock.
- `rd_weight_rst`  in  1  reset, asynchronous, active-high (clock `clk_i`).
- `start_i`  in  1  begin a transfer; sampled only in IDLE.
- `base_addr_i`  in  ADDR_WIDTH  first write address; sampled with `start_i`.
- `n_words_i`  in  ADDR_WIDTH  number of full words to write; sampled with `start_i`.
- `flush_i`  in  1  terminate the transfer early; only honoured in FILL.
- `w_data_i`  in  F_WIDTH  weight beat.
- `w_valid_i`  in  1  `w_data_i` is valid.
- `w_ready_o`  out  1  block accepts a beat.
- `mem2_data_o`  out  N_ROWS_ARRAY*F_WIDTH  packed word; lane k occupies bits [(k+1)*F_WIDTH-1 : k*F_WIDTH].
- `wr_addrs_mem2_o`  out  ADDR_WIDTH  write address.
- `wr_mem2_ld_o`  out  1  write strobe, one cycle per word.
- `busy_o`  out  1  high in FILL and WRITE.
- `done_o`  out  1  one-cycle end-of-transfer pulse.

## Operation

States: IDLE, FILL, WRITE, DONE.

- **Reset (asynchronous, immediate).** State goes to IDLE. Every output is 0, including the `mem2_data_o` lanes, `wr_addrs_mem2_o` and `w_ready_o`. The lane counter, word counter and address register are cleared.
- **IDLE.**
  - `start_i`=1 latches `base_addr_i` and `n_words_i`.
  - If `n_words_i`=0, next state is DONE.
  - Otherwise next state is FILL, with lane=0 and all lanes zeroed.
  - `start_i` in any other state is ignored.
- **FILL.**
  - `w_ready_o`=1.
  - A beat is accepted when `w_valid_i` && `w_ready_o`. It is stored in lane[lane_cnt], the first beat of a word going to lane 0, and lane_cnt increments.
  - Acceptance of beat N_ROWS_ARRAY-1 moves the state to WRITE.
- **WRITE** (exactly one cycle).
  - `wr_mem2_ld_o`=1, `w_ready_o`=0.
  - `wr_addrs_mem2_o` = current address and `mem2_data_o` = packed lanes, both stable for the whole cycle.
  - Afterwards the address increments (mod 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000) and words_left decrements.
  - If words_left reaches 0, next state is DONE. Otherwise next state is FILL with lanes zeroed and lane_cnt=0.
- **DONE.** `done_o`=1 for one cycle, then IDLE.
- **Flush in FILL.**
  - A beat accepted in the same cycle as `flush_i` is stored first.
  - If lane_cnt after that beat is greater than 0, next state is WRITE. The unfilled lanes are 0, and DONE follows regardless of words_left.
  - If lane_cnt is 0, next state is DONE with no write.
  - If the flush cycle also completes a full word, behaviour is the same: one write, then DONE.
- **Arithmetic.** Weights are stored bit-exact with no sign extension or saturation. words_left and the address are ADDR_WIDTH bits.
- **Holding.** `mem2_data_o` and `wr_addrs_mem2_o` hold their last values outside WRITE. Only the strobe qualifies them.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- `start_i` at cycle t puts the block in FILL at t+1, with `w_ready_o`=1 from t+1.
- The last beat of a word accepted at cycle t gives the write strobe at t+1. Beats resume at t+2.
- Sustained throughput is N_ROWS_ARRAY+1 cycles per word (21 at default parameters).
- With `n_words_i`=0, `start_i` at t gives `done_o` at t+1.
- After the final WRITE at cycle t, `done_o` is high at t+1 and the block is IDLE at t+2. A new `start_i` is accepted at t+2.
- `busy_o` falls in the DONE cycle.
- Reset asserted mid-FILL or mid-WRITE aborts the transfer:
  - any in-progress strobe drops immediately;
  - the partial word is discarded;
  - no `done_o` is issued.

## Test plan

1. **Two full words.** `base_addr_i`=0x0010, `n_words_i`=2, continuous valid with weights 1..40. Required response:
   - a write at 0x0010 with `mem2_data_o`[7:0]=0x01 and [159:152]=0x14;
   - a write at 0x0011 with lane0=0x15 and lane19=0x28;
   - `w_ready_o` low in both WRITE cycles;
   - `done_o` one cycle after the second strobe.
2. **Backpressure and signed data.** Valid toggled pseudo-randomly, `n_words_i`=1, weights alternating -1/-128. Required: lane values 0xFF/0x80 in order, no beat lost or duplicated, and exactly one strobe.
3. **Zero words.** `n_words_i`=0. Required: `done_o` one cycle after `start_i`, no strobe, `w_ready_o` never 1.
4. **Early flush.** Flush asserted together with the 5th accepted beat (weights 1..5), `n_words_i`=3. Required: a single write with lanes 0-4 = 1..5 and lanes 5-19 = 0, then `done_o`.
5. **Address wrap.** `base_addr_i`=0xFFFF, `n_words_i`=2. Required: writes at 0xFFFF, then 0x0000.
6. **Reset mid-transfer.** Pulse `rd_weight_rst` after 7 beats of a word. Required:
   - all outputs are 0 within the same cycle;
   - a following start with 20 beats writes a word whose lane 0 is the first post-reset beat.
